aibcr3aux_lvshift_seq: RTL and testbench

AIBCR3AUX_LVSHIFT_SEQ -- requirements
Module: aibcr3aux_lvshift_seq

---
 rtl/aibcr3aux_lvshift_pkg.sv | 21 ++
 rtl/aibcr3aux_sync2.sv | 31 +++
 rtl/aibcr3aux_lvshift_seq.sv | 126 ++++++++++++
 tb/tb_aibcr3aux_lvshift_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/aibcr3aux_lvshift_pkg.sv
// ---------------------------------------------------------------------------
// aibcr3aux_lvshift_pkg
// Shared types and constants for the AUX level-shifter power sequencer.
//   STATE_W     : width of the power-state encoding (also the pwr_state port)
//   CNT_W       : width of the RAMP debounce counter
//   pwr_state_e : OFF(0) VCC_ONLY(1) VCCL_ONLY(2) RAMP(3) ON(4)
// ---------------------------------------------------------------------------
package aibcr3aux_lvshift_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF       = 3'd0,
        ST_VCC_ONLY  = 3'd1,
        ST_VCCL_ONLY = 3'd2,
        ST_RAMP      = 3'd3,
        ST_ON        = 3'd4
    } pwr_state_e;

endpackage

// File: rtl/aibcr3aux_sync2.sv
// ---------------------------------------------------------------------------
// aibcr3aux_sync2
// Two-flop synchroniser for one asynchronous bit, cleared by sync reset.
//   clk_i : sampling clock
//   rst_i : synchronous active-high reset (both flops to 0)
//   d_i   : asynchronous input
//   q_o   : synchronised output (2-cycle latency)
// ---------------------------------------------------------------------------
module aibcr3aux_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/aibcr3aux_lvshift_seq.sv
// ---------------------------------------------------------------------------
// aibcr3aux_lvshift_seq
// Power sequencer for the AUX level shifter. Both supply-present indicators
// are synchronised, then a small FSM decides whether the NCH-bit data path
// is passed through (ON), clamped (VCC_ONLY) or forced low (all else).
// Entry to ON is debounced for DBNC cycles in RAMP; loss is immediate.
//
// Ports:
//   clk            : sole clock
//   reset          : synchronous active-high reset
//   vccl_aibcr3aux : low-voltage supply present (asynchronous)
//   vcc_aibcr3aux  : high-voltage supply present (asynchronous)
//   in [NCH]       : low-domain data
//   out [NCH]      : shifted / clamped data, registered
//   pwr_good       : high only in ON, registered
//   pwr_state [3]  : current state encoding, registered
//
// Build option: AIBCR3AUX_LVSHIFT_XPROP_EN -- when defined, an unknown
// synchronised supply value drives out and pwr_state to X for that cycle
// (simulation aid). When undefined, unknown supply values count as 0.
// ---------------------------------------------------------------------------
module aibcr3aux_lvshift_seq
    import aibcr3aux_lvshift_pkg::*;
#(
    parameter int             NCH       = 8,
    parameter int             DBNC      = 4,
    parameter logic [NCH-1:0] CLAMP_VAL = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vccl_aibcr3aux,
    input  logic               vcc_aibcr3aux,
    input  logic [NCH-1:0]     in,
    output logic [NCH-1:0]     out,
    output logic               pwr_good,
    output logic [STATE_W-1:0] pwr_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC - 1);

    // ---- supply synchronisers: bit 1 = vccl, bit 0 = vcc ----
    logic [1:0] sup_raw;
    logic [1:0] sup_sync;

    assign sup_raw = {vccl_aibcr3aux, vcc_aibcr3aux};

    for (genvar g = 0; g < 2; g++) begin : g_sync
        aibcr3aux_sync2 u_sync (
            .clk_i (clk),
            .rst_i (reset),
            .d_i   (sup_raw[g]),
            .q_o   (sup_sync[g])
        );
    end

    logic sv, svl;
    logic sv_ok, svl_ok;

    assign sv  = sup_sync[0];
    assign svl = sup_sync[1];
    // Only a solid 1 counts as "present"; X/Z fall to absent.
    assign sv_ok  = (sv  === 1'b1);
    assign svl_ok = (svl === 1'b1);

    // ---- state / counter registers ----
    pwr_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]     out_q, out_d;
    logic               pwr_good_q;
    logic [STATE_W-1:0] pwr_state_q;

    always_comb begin
        state_d = state_q;
        unique case ({svl_ok, sv_ok})
            2'b00: state_d = ST_OFF;
            2'b01: state_d = ST_VCC_ONLY;
            2'b10: state_d = ST_VCCL_ONLY;
            2'b11: begin
                if (state_q == ST_RAMP) begin
                    if (cnt_q == CNT_LAST) state_d = ST_ON;
                end else if (state_q != ST_ON) begin
                    state_d = ST_RAMP;
                end
            end
        endcase

        // Counter only runs while staying in RAMP; any exit (to ON or on a
        // supply drop) clears it so re-entry starts from 0.
        cnt_d = (state_q == ST_RAMP && state_d == ST_RAMP) ? cnt_q + 1'b1 : '0;

        // Output decoded from the next state so data, state and pwr_good
        // all change on the same edge.
        unique case (state_d)
            ST_ON:       out_d = in;
            ST_VCC_ONLY: out_d = CLAMP_VAL;
            default:     out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            out_q       <= '0;
            pwr_good_q  <= 1'b0;
            pwr_state_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            pwr_good_q  <= (state_d == ST_ON);
            pwr_state_q <= state_d;
`ifdef AIBCR3AUX_LVSHIFT_XPROP_EN
            if ($isunknown({svl, sv})) begin
                out_q       <= 'x;
                pwr_state_q <= 'x;
            end
`endif
        end
    end

    assign out       = out_q;
    assign pwr_good  = pwr_good_q;
    assign pwr_state = pwr_state_q;

endmodule

// File: tb/tb_aibcr3aux_lvshift_seq.sv
// ---------------------------------------------------------------------------
// tb_aibcr3aux_lvshift_seq
// Directed bench: a per-cycle vector table (reset, power-up, data pass,
// clamp, supply loss) followed by hand-written multi-cycle sequences for
// loss-in-ON, toggle-in-RAMP and reset-mid-RAMP.
// Row convention: inputs are set 1ns after an edge, the next edge samples
// them, and outputs are checked 1ns after that edge.
// ---------------------------------------------------------------------------
module tb_aibcr3aux_lvshift_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       vccl, vcc;
    logic [7:0] din;
    logic [7:0] dout;
    logic       pwr_good;
    logic [2:0] pwr_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aibcr3aux_lvshift_seq #(.NCH(8), .DBNC(4), .CLAMP_VAL(8'hFF)) dut (
        .clk            (clk),
        .reset          (reset),
        .vccl_aibcr3aux (vccl),
        .vcc_aibcr3aux  (vcc),
        .in             (din),
        .out            (dout),
        .pwr_good       (pwr_good),
        .pwr_state      (pwr_state)
    );

    typedef struct {
        logic       rst;
        logic       vl;
        logic       vh;
        logic [7:0] d;
        logic [2:0] st;
        logic [7:0] o;
    } vec_t;

    vec_t tv[26];

    task automatic drive(input logic r, input logic l, input logic h, input logic [7:0] d);
        reset = r; vccl = l; vcc = h; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic [7:0] o);
        logic g;
        g = (st == 3'd4);
        total++;
        if (dout !== o || pwr_state !== st || pwr_good !== g) begin
            bad++;
            $display("FAIL %s: got out=%h st=%0d good=%b, want out=%h st=%0d good=%b",
                     nm, dout, pwr_state, pwr_good, o, st, g);
        end
    endtask

    task automatic step(input string nm, input logic r, input logic l, input logic h,
                        input logic [7:0] d, input logic [2:0] st, input logic [7:0] o);
        drive(r, l, h, d);
        chk(nm, st, o);
    endtask

    initial begin
        // rst vl vh  in      st    out
        tv[0]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 8'h00};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 8'h00};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, 8'h00};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, 8'h00};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 8'h11, 3'd0, 8'h00};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 8'h22, 3'd0, 8'h00};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 8'h33, 3'd3, 8'h00};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 8'h44, 3'd3, 8'h00};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 8'h55, 3'd3, 8'h00};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 8'h66, 3'd3, 8'h00};
        tv[10] = '{1'b0, 1'b1, 1'b1, 8'h3C, 3'd4, 8'h3C};
        tv[11] = '{1'b0, 1'b1, 1'b1, 8'hC3, 3'd4, 8'hC3};
        tv[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 3'd4, 8'h00};
        tv[13] = '{1'b0, 1'b1, 1'b1, 8'hFF, 3'd4, 8'hFF};
        tv[14] = '{1'b0, 1'b0, 1'b1, 8'h5A, 3'd4, 8'h5A};
        tv[15] = '{1'b0, 1'b0, 1'b1, 8'hA5, 3'd4, 8'hA5};
        tv[16] = '{1'b0, 1'b0, 1'b1, 8'h12, 3'd1, 8'hFF};
        tv[17] = '{1'b0, 1'b0, 1'b1, 8'h34, 3'd1, 8'hFF};
        tv[18] = '{1'b0, 1'b1, 1'b0, 8'h56, 3'd1, 8'hFF};
        tv[19] = '{1'b0, 1'b1, 1'b0, 8'h78, 3'd1, 8'hFF};
        tv[20] = '{1'b0, 1'b1, 1'b0, 8'h9A, 3'd2, 8'h00};
        tv[21] = '{1'b0, 1'b1, 1'b0, 8'hBC, 3'd2, 8'h00};
        tv[22] = '{1'b0, 1'b0, 1'b0, 8'hDE, 3'd2, 8'h00};
        tv[23] = '{1'b0, 1'b0, 1'b0, 8'hF0, 3'd2, 8'h00};
        tv[24] = '{1'b0, 1'b0, 1'b0, 8'h0F, 3'd0, 8'h00};
        tv[25] = '{1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, 8'h00};

        reset = 1'b1; vccl = 1'b0; vcc = 1'b0; din = 8'h00;

        for (int i = 0; i < 26; i++) begin
            drive(tv[i].rst, tv[i].vl, tv[i].vh, tv[i].d);
            chk($sformatf("tbl%0d", i), tv[i].st, tv[i].o);
        end

        // ---- vcc drops for one cycle while ON ----
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 8'h00);
        step("glitch_on_pre",  1'b0, 1'b1, 1'b1, 8'h81, 3'd4, 8'h81);
        step("glitch_k0",      1'b0, 1'b1, 1'b0, 8'h82, 3'd4, 8'h82);
        step("glitch_k1",      1'b0, 1'b1, 1'b1, 8'h83, 3'd4, 8'h83);
        step("glitch_k2_left", 1'b0, 1'b1, 1'b1, 8'h84, 3'd2, 8'h00);
        for (int i = 0; i < 4; i++)
            step($sformatf("glitch_ramp%0d", i), 1'b0, 1'b1, 1'b1, 8'h90, 3'd3, 8'h00);
        step("glitch_on_again", 1'b0, 1'b1, 1'b1, 8'h96, 3'd4, 8'h96);

        // ---- vcc toggles inside RAMP: count restarts on re-entry ----
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step("tog_r0", 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 8'h00);
        step("tog_r1", 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 8'h00);
        step("tog_r2", 1'b0, 1'b1, 1'b1, 8'h00, 3'd3, 8'h00);
        step("tog_r3", 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 8'h00);
        step("tog_r4", 1'b0, 1'b1, 1'b1, 8'h00, 3'd3, 8'h00);
        step("tog_r5", 1'b0, 1'b1, 1'b1, 8'h00, 3'd2, 8'h00);
        for (int i = 0; i < 4; i++)
            step($sformatf("tog_ramp%0d", i), 1'b0, 1'b1, 1'b1, 8'h00, 3'd3, 8'h00);
        step("tog_on", 1'b0, 1'b1, 1'b1, 8'h7E, 3'd4, 8'h7E);

        // ---- reset mid-RAMP at count 2 ----
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        step("mid_r2", 1'b0, 1'b1, 1'b1, 8'h00, 3'd3, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        step("mid_r4", 1'b0, 1'b1, 1'b1, 8'h00, 3'd3, 8'h00);
        total++;
        if (dut.cnt_q !== 8'd2) begin
            bad++;
            $display("FAIL mid_cnt2: got cnt=%0d want 2", dut.cnt_q);
        end
        step("mid_rst", 1'b1, 1'b1, 1'b1, 8'hEE, 3'd0, 8'h00);
        total++;
        if (dut.cnt_q !== 8'd0) begin
            bad++;
            $display("FAIL mid_cnt0: got cnt=%0d want 0", dut.cnt_q);
        end
        step("post_rst0", 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 8'h00);
        step("post_rst1", 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 8'h00);
        for (int i = 0; i < 4; i++)
            step($sformatf("post_ramp%0d", i), 1'b0, 1'b1, 1'b1, 8'h00, 3'd3, 8'h00);
        step("post_on", 1'b0, 1'b1, 1'b1, 8'h5C, 3'd4, 8'h5C);

`ifdef AIBCR3AUX_LVSHIFT_XPROP_EN
        // ---- unknown vcc propagates to outputs ----
        drive(1'b0, 1'b1, 1'bx, 8'h5C);
        drive(1'b0, 1'b1, 1'bx, 8'h5C);
        drive(1'b0, 1'b1, 1'bx, 8'h5C);
        total++;
        if (dout !== 8'bxxxx_xxxx || pwr_state !== 3'bxxx) begin
            bad++;
            $display("FAIL xprop: got out=%b st=%b want all x", dout, pwr_state);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
